// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// fifo_wr_arbiter
// Shares the write port of an 8-deep FIFO among N_REQ valid/ready producers
// in the FIFO write-clock domain. One producer is granted at a time in
// round-robin order, for at most MAX_BURST words per grant. The FIFO full flag
// is honoured, so no write is ever issued while the FIFO is full.
//
// Ports:
//   wclk        write-domain clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester word valid            [N_REQ]
//   req_data    per-requester data, i at [i*DW+:DW] [N_REQ*DW]
//   req_ready   per-requester accept                [N_REQ]
//   fifo_full   FIFO full flag
//   fifo_wr_en  FIFO write enable
//   fifo_din    FIFO write data                     [DW]
//   grant_id    granted requester (valid when busy) [IDW]
//   busy        a grant is active
//   xfer_count  words written since reset, wraps    [16]
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4,
  parameter int IDW       = 2
) (
  input  logic                wclk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_din,
  output logic [IDW-1:0]      grant_id,
  output logic                busy,
  output logic [15:0]         xfer_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [3:0]     MAX_BURST_C = 4'(MAX_BURST);
  // Reset value of last_winner makes requester 0 the first candidate.
  localparam logic [IDW-1:0] LAST_RST_C  = IDW'(N_REQ - 1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic [IDW-1:0]   last_winner_q, last_winner_d;
  logic [15:0]      xfer_count_q, xfer_count_d;

  logic             gnt_valid_s;
  logic [DW-1:0]    gnt_data_s;
  logic             transfer_s;
  logic             any_valid_s;
  logic             grant_exit_s;

  // Round-robin pick: first requester with valid set, scanning from the one
  // after 'last' and wrapping mod N_REQ; 'last' itself is the final candidate.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                             input logic [IDW-1:0]   last);
    logic [IDW-1:0]   pick;
    logic             found;
    logic [N_REQ-1:0] shifted;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx     = (int'(last) + k) % N_REQ;
      shifted = v >> idx;
      if (!found && shifted[0]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Select the granted requester's valid/data and drive the per-requester readies.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_data_s  = '0;
    req_ready   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        gnt_valid_s  = req_valid[i];
        gnt_data_s   = req_data[i*DW +: DW];
        req_ready[i] = busy_q && !fifo_full;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // FIFO write side is purely combinational off the registered grant, so a
  // reset drops it immediately through busy_q.
  always_comb begin
    transfer_s  = busy_q && gnt_valid_s && !fifo_full;
    any_valid_s = |req_valid;
    fifo_wr_en  = transfer_s;
    if (busy_q) begin
      fifo_din = gnt_data_s;
    end else begin
      fifo_din = '0;
    end
  end

  // Next-state logic for the grant FSM, burst counter and word counter.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    grant_id_d    = grant_id_q;
    burst_cnt_d   = burst_cnt_q;
    last_winner_d = last_winner_q;
    grant_exit_s  = 1'b0;

    if (transfer_s) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end else begin
      xfer_count_d = xfer_count_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_d     = ST_GRANT;
          busy_d      = 1'b1;
          grant_id_d  = rr_pick(req_valid, last_winner_q);
          burst_cnt_d = 4'd0;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Full alone never ends a grant: with valid held, nothing here moves.
        grant_exit_s = (transfer_s && ((burst_cnt_q + 4'd1) == MAX_BURST_C)) ||
                       !gnt_valid_s;
        if (transfer_s) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
        if (grant_exit_s) begin
          last_winner_d = grant_id_q;
          if (any_valid_s) begin
            // Zero-bubble handover; the current holder may win again.
            grant_id_d  = rr_pick(req_valid, grant_id_q);
            burst_cnt_d = 4'd0;
          end else begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            burst_cnt_d = 4'd0;
          end
        end else begin
          last_winner_d = last_winner_q;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        busy_d        = 1'b0;
        grant_id_d    = '0;
        burst_cnt_d   = 4'd0;
        last_winner_d = LAST_RST_C;
      end
    endcase
  end

  // State registers; an in-flight word is dropped by the async reset.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      grant_id_q    <= '0;
      burst_cnt_q   <= 4'd0;
      last_winner_q <= LAST_RST_C;
      xfer_count_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      grant_id_q    <= grant_id_d;
      burst_cnt_q   <= burst_cnt_d;
      last_winner_q <= last_winner_d;
      xfer_count_q  <= xfer_count_d;
    end
  end

  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// Testbench for fifo_wr_arbiter: table-driven single-requester sequence,
// directed corner cases and randomized traffic, all checked every cycle
// against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int MB  = 4;
  localparam int IDW = 2;
  localparam int QD  = 65600;

  logic            wclk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic [15:0]     xfer_count;

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB), .IDW(IDW)) dut (
    .wclk(wclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy), .xfer_count(xfer_count)
  );

  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  // producer queues (array + head/tail)
  logic [15:0] p_mem [N][QD];
  int          p_head [N];
  int          p_tail [N];
  logic [N-1:0]    cur_v;
  logic [N*DW-1:0] cur_d;

  // sampled DUT outputs of the current cycle
  logic           s_busy, s_wr;
  logic [IDW-1:0] s_gid;
  logic [N-1:0]   s_rdy;
  logic [DW-1:0]  s_din;
  logic [15:0]    s_xc;
  logic [15:0]    wr_log [$];

  // reference model: who holds the port, how many words in this grant so far
  bit m_busy;
  int m_gid, m_cnt, m_last, m_xfer;

  typedef struct {
    logic        v0;
    logic [15:0] d0;
    logic        e_busy;
    logic        e_wr;
    logic        e_rdy0;
    logic [15:0] e_din;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] v, input int after);
    for (int k = 1; k <= N; k++) begin
      if (v[(after + k) % N]) return (after + k) % N;
    end
    return after;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_gid = 0; m_cnt = 0; m_last = N - 1; m_xfer = 0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic full);
    logic          e_wr;
    logic [N-1:0]  e_rdy;
    logic [DW-1:0] e_din;
    e_wr  = m_busy && v[m_gid] && !full;
    e_rdy = (m_busy && !full) ? (N'(1) << m_gid) : '0;
    e_din = m_busy ? d[m_gid*DW +: DW] : '0;
    chk("busy", {31'd0, s_busy}, {31'd0, m_busy});
    if (m_busy) chk("grant_id", {30'd0, s_gid}, m_gid);
    chk("req_ready", {28'd0, s_rdy}, {28'd0, e_rdy});
    chk("fifo_wr_en", {31'd0, s_wr}, {31'd0, e_wr});
    chk("fifo_din", {16'd0, s_din}, {16'd0, e_din});
    chk("xfer_count", {16'd0, s_xc}, m_xfer);
    if (e_wr) begin
      m_xfer = (m_xfer + 1) % 65536;
      m_cnt++;
    end
    if (!m_busy) begin
      if (v != '0) begin
        m_busy = 1'b1; m_gid = rr_next(v, m_last); m_cnt = 0;
      end
    end else if ((e_wr && m_cnt == MB) || !v[m_gid]) begin
      m_last = m_gid;
      if (v != '0) begin
        m_gid = rr_next(v, m_gid); m_cnt = 0;
      end else begin
        m_busy = 1'b0; m_cnt = 0;
      end
    end
  endtask

  // one clock cycle: drive at posedge+1, sample at posedge+3, return at next posedge+1
  task automatic apply(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic full);
    req_valid = v; req_data = d; fifo_full = full;
    #2;
    s_busy = busy; s_gid = grant_id; s_rdy = req_ready; s_wr = fifo_wr_en;
    s_din = fifo_din; s_xc = xfer_count;
    model_step(v, d, full);
    if (s_wr) wr_log.push_back(s_din);
    @(posedge wclk); #1;
  endtask

  task automatic drive_queues();
    cur_v = '0; cur_d = '0;
    for (int i = 0; i < N; i++) begin
      if (p_head[i] != p_tail[i]) begin
        cur_v[i] = 1'b1;
        cur_d[i*DW +: DW] = p_mem[i][p_head[i]];
      end
    end
  endtask

  task automatic pcycle(input logic full);
    drive_queues();
    apply(cur_v, cur_d, full);
    for (int i = 0; i < N; i++) begin
      if (cur_v[i] && s_rdy[i]) p_head[i]++;
    end
  endtask

  task automatic push(input int i, input logic [15:0] w);
    p_mem[i][p_tail[i]] = w;
    p_tail[i]++;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      p_head[i] = 0; p_tail[i] = 0;
    end
    wr_log.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    clear_queues();
    model_reset();
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_xfer", {16'd0, xfer_count}, 32'd0);
    @(posedge wclk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [15:0] exp_w;
    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    @(posedge wclk); #1;

    // ---- test 1: table-driven single requester, 6 words ----
    tbl[0] = '{1'b1, 16'hA000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 16'hA000, 1'b1, 1'b1, 1'b1, 16'hA000};
    tbl[2] = '{1'b1, 16'hA001, 1'b1, 1'b1, 1'b1, 16'hA001};
    tbl[3] = '{1'b1, 16'hA002, 1'b1, 1'b1, 1'b1, 16'hA002};
    tbl[4] = '{1'b1, 16'hA003, 1'b1, 1'b1, 1'b1, 16'hA003};
    tbl[5] = '{1'b1, 16'hA004, 1'b1, 1'b1, 1'b1, 16'hA004};
    tbl[6] = '{1'b1, 16'hA005, 1'b1, 1'b1, 1'b1, 16'hA005};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      apply({3'b000, tbl[k].v0}, {48'h0, tbl[k].d0}, 1'b0);
      chk($sformatf("t1_busy[%0d]", k), {31'd0, s_busy}, {31'd0, tbl[k].e_busy});
      chk($sformatf("t1_wr[%0d]", k), {31'd0, s_wr}, {31'd0, tbl[k].e_wr});
      chk($sformatf("t1_rdy0[%0d]", k), {31'd0, s_rdy[0]}, {31'd0, tbl[k].e_rdy0});
      chk($sformatf("t1_din[%0d]", k), {16'd0, s_din}, {16'd0, tbl[k].e_din});
      if (tbl[k].e_busy) chk($sformatf("t1_gid[%0d]", k), {30'd0, s_gid}, 32'd0);
    end
    chk("t1_xfer", {16'd0, xfer_count}, 32'd6);

    // ---- test 2: all four always valid, round-robin with full bursts ----
    do_reset();
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 8; n++) push(i, 16'(16'h1000 * i + n));
    for (int c = 0; c < 21; c++) pcycle(1'b0);
    chk("t2_nwrites", wr_log.size(), 32'd20);
    for (int k = 0; k < 20 && k < wr_log.size(); k++) begin
      exp_w = 16'(16'h1000 * ((k / 4) % 4) + (k % 4) + 4 * (k / 16));
      chk($sformatf("t2_din[%0d]", k), {16'd0, wr_log[k]}, {16'd0, exp_w});
    end

    // ---- test 3: full stall mid-burst from requester 1 ----
    do_reset();
    for (int n = 0; n < 4; n++) push(1, 16'(16'h1000 + n));
    for (int c = 0; c < 10; c++) begin
      pcycle((c >= 3 && c <= 5) ? 1'b1 : 1'b0);
      if (c >= 3 && c <= 5) begin
        chk("t3_stall_wr", {31'd0, s_wr}, 32'd0);
        chk("t3_stall_rdy", {28'd0, s_rdy}, 32'd0);
        chk("t3_stall_gid", {30'd0, s_gid}, 32'd1);
        chk("t3_stall_busy", {31'd0, s_busy}, 32'd1);
      end
    end
    chk("t3_nwrites", wr_log.size(), 32'd4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++)
      chk($sformatf("t3_din[%0d]", k), {16'd0, wr_log[k]}, 32'h1000 + k);

    // ---- test 4: requester 0 drops after 2 words, requester 2 takes over ----
    do_reset();
    push(0, 16'h0A00); push(0, 16'h0A01);
    for (int n = 0; n < 3; n++) push(2, 16'(16'h2000 + n));
    for (int c = 0; c < 8; c++) begin
      pcycle(1'b0);
      if (c == 1) chk("t4_gid0", {30'd0, s_gid}, 32'd0);
      if (c == 3) begin
        chk("t4_exit_wr", {31'd0, s_wr}, 32'd0);
        chk("t4_exit_busy", {31'd0, s_busy}, 32'd1);
      end
      if (c == 4) begin
        chk("t4_gid2", {30'd0, s_gid}, 32'd2);
        chk("t4_din2", {16'd0, s_din}, 32'h2000);
      end
    end

    // ---- test 5: async reset mid-burst ----
    do_reset();
    for (int n = 0; n < 4; n++) push(2, 16'(16'h2000 + n));
    pcycle(1'b0);
    pcycle(1'b0);
    drive_queues();
    req_valid = cur_v; req_data = cur_d; fifo_full = 1'b0;
    #1;
    chk("t5_wr_before", {31'd0, fifo_wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_wr_in_reset", {31'd0, fifo_wr_en}, 32'd0);
    chk("t5_rdy_in_reset", {28'd0, req_ready}, 32'd0);
    chk("t5_busy_in_reset", {31'd0, busy}, 32'd0);
    clear_queues();
    model_reset();
    req_valid = '0; req_data = '0;
    #1;
    rst_n = 1'b1;
    @(posedge wclk); #1;
    push(1, 16'h1111); push(1, 16'h1112);
    push(3, 16'h3333); push(3, 16'h3334);
    for (int c = 0; c < 8; c++) begin
      pcycle(1'b0);
      if (c == 1) begin
        chk("t5_winner", {30'd0, s_gid}, 32'd1);
        chk("t5_first_din", {16'd0, s_din}, 32'h1111);
      end
    end

    // ---- randomized traffic against the model ----
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (p_head[i] == p_tail[i] && $urandom_range(0, 3) == 0) begin
          cnt = $urandom_range(1, 6);
          for (int n = 0; n < cnt; n++) push(i, 16'($urandom));
        end
      end
      pcycle($urandom_range(0, 3) == 0);
    end

    // ---- test 6: idle stretch, then counter wrap ----
    do_reset();
    for (int c = 0; c < 20; c++) pcycle(1'b0);
    chk("t6_idle_xfer", {16'd0, xfer_count}, 32'd0);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    for (int n = 0; n < 65537; n++) push(0, 16'(n));
    cnt = 0;
    while (p_head[0] != p_tail[0] && cnt < 70000) begin
      pcycle(1'b0);
      cnt++;
    end
    chk("t6_drained", {31'd0, (p_head[0] == p_tail[0])}, 32'd1);
    for (int c = 0; c < 3; c++) pcycle(1'b0);
    chk("t6_xfer_wrap", {16'd0, xfer_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the 16-bit write port of the team's 8-deep FIFO among N_REQ producers in the FIFO's write-clock domain.
- Each producer has a valid/ready stream. The arbiter grants one producer at a time, round-robin.
- A grant lasts at most MAX_BURST words, then arbitration runs again.
- It drives the FIFO's wr_en/in directly and honours the FIFO's full flag, so the FIFO never sees a write while full.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 16, data width
- MAX_BURST, 4, max words per grant (1..15)
- IDW, 2, grant index width, clog2(N_REQ)

Ports:
- wclk  in  1  write-domain clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  N_REQ  per-requester word valid
- req_data  in  N_REQ*DW  per-requester data; requester i occupies bits [i*DW +: DW]
- req_ready  out  N_REQ  per-requester accept
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_din  out  DW  FIFO write data
- grant_id  out  IDW  index of the granted requester (valid when busy=1)
- busy  out  1  a grant is active
- xfer_count  out  16  total words written since reset; wraps

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, busy=0, grant_id=0, burst_cnt=0.
  - last_winner=N_REQ-1, so requester 0 has first priority.
  - xfer_count=0.
  - req_ready=0 and fifo_wr_en=0 immediately, combinationally via busy=0.
- Requester contract:
  - Once req_valid[i] rises, it and its data hold until the cycle where req_valid[i] && req_ready[i].
  - The arbiter is not required to tolerate violations.
- Combinational datapath:
  - g = grant_id.
  - req_ready[g] = busy && !fifo_full; all other ready bits are 0.
  - fifo_wr_en = busy && req_valid[g] && !fifo_full.
  - fifo_din = req_data[g] when busy, else 0.
  - transfer = fifo_wr_en.
- RR(start): first i in order start, start+1, ..., mod N_REQ with req_valid[i]=1, sampled at the current edge.
- IDLE:
  - If any req_valid: next state GRANT, grant_id=RR(last_winner+1), burst_cnt=0, busy=1.
  - This costs one arbitration cycle: the first write happens the cycle after the grant registers.
  - Otherwise stay in IDLE.
- GRANT:
  - Each transfer: burst_cnt+1, xfer_count+1.
  - Exit condition A: a transfer that brings burst_cnt to MAX_BURST.
  - Exit condition B: req_valid[g]=0 (granted requester has no more data).
  - On exit: last_winner=g. If any req_valid at that edge, stay in GRANT with grant_id=RR(g+1) and burst_cnt=0. This is a zero-bubble handover; g may win again if it is the only requester. Otherwise go to IDLE, busy=0.
- No exit on fifo_full alone:
  - While full, the grant holds, burst_cnt holds, no timeout.
  - A full-stall cycle where req_valid[g]=1 is not an exit.
- Simultaneous events:
  - A transfer that reaches MAX_BURST in the same cycle fifo_full rises is still counted; full only affects later cycles.
  - Requests arriving mid-burst wait for the exit.
- Width/wrap:
  - burst_cnt is 4 bits.
  - grant index arithmetic is mod N_REQ.
  - xfer_count wraps at 0xFFFF -> 0x0000.
- Reset mid-burst: the in-flight word is not written; all state returns to reset values.

Test Plan:
1. Reset; req_valid[0]=1 with words 0xA000..0xA005 (6 words), MAX_BURST=4, FIFO drained -> grant in cycle 1, writes 0xA000..0xA003 in cycles 2-5, re-grant of requester 0 with no bubble, writes 0xA004-0xA005 in cycles 6-7, then IDLE; xfer_count=6.
2. All four requesters always valid, data 0x1000*i+n -> grant_id sequence 0,1,2,3,0; exactly 4 writes per grant; fifo_din order 0x0000-0x0003, 0x1000-0x1003, ...; no idle cycles between grants.
3. fifo_full=1 for 3 cycles after 2 words of a burst from requester 1 -> req_ready=0 and fifo_wr_en=0 for those cycles, grant_id=1 held, burst_cnt=2 held; 2 remaining words written after full drops.
4. Requester 0 sends 2 words then drops valid while requester 2 is valid -> next edge grant_id=2 (requester 1 idle is skipped); no write in the exit cycle.
5. rst_n pulsed low mid-burst (async, between edges) -> req_ready and fifo_wr_en fall within the same cycle; after release with requesters 1 and 3 both valid, requester 1 wins.
6. No requests for 20 cycles -> busy=0, fifo_wr_en=0, all req_ready=0, xfer_count unchanged. Then write 65537 words -> xfer_count=1.
